// File: rtl/component_decode_sequencer_if.sv
// Decoder-side bundle between the component decode sequencer and its two VLDs.
//
// Handshake: *_vld_valid is a single-cycle strobe with no ready back-channel.
// A strobe is consumed only while the matching *_vld_enable is high and the
// sequencer is in that decoder's run phase. Strobes at any other time are
// dropped. An AC strobe with ac_vld_pos_inc == 0 is also dropped.
interface component_decode_sequencer_if;
    logic       dc_vld_valid;
    logic       dc_vld_reset_n;
    logic       dc_vld_enable;
    logic       ac_vld_valid;
    logic [6:0] ac_vld_pos_inc;
    logic       ac_vld_reset_n;
    logic       ac_vld_input_start;
    logic       ac_vld_enable;
    logic       ac_vld_flush;

    // Sequencer side: drives decoder control and receives decoder strobes.
    modport master (
        input  dc_vld_valid, ac_vld_valid, ac_vld_pos_inc,
        output dc_vld_reset_n, dc_vld_enable,
        output ac_vld_reset_n, ac_vld_input_start, ac_vld_enable, ac_vld_flush
    );

    // Decoder side: mirror of the master modport.
    modport slave (
        output dc_vld_valid, ac_vld_valid, ac_vld_pos_inc,
        input  dc_vld_reset_n, dc_vld_enable,
        input  ac_vld_reset_n, ac_vld_input_start, ac_vld_enable, ac_vld_flush
    );
endinterface

// File: rtl/component_decode_sequencer.sv
// Component decode sequencer for the ProRes decode path.
//
// Per component, the sequencer runs these phases in order:
//   1. DC VLD run.
//   2. AC run/level VLD run.
//   3. A fixed-length dequant/IDCT window.
// It counts decoded coefficients and reports done or error.
//
// Optional macro SEQ_TIMEOUT_EN adds a stall watchdog on the two run phases.
module component_decode_sequencer #(
    parameter int RESET_CYCLES   = 1,
    parameter int IDCT_LATENCY   = 10,
    parameter int MAX_BLOCKS     = 32,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] block_num,
    component_decode_sequencer_if.master vld,
    output logic        busy,
    output logic [31:0] dc_vld_counter,
    output logic [31:0] ac_vld_counter,
    output logic        idct_enable,
    output logic        done,
    output logic        error,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DC_INIT = 3'd1,
        DC_RUN  = 3'd2,
        AC_INIT = 3'd3,
        AC_RUN  = 3'd4,
        IDCT    = 3'd5,
        DONE    = 3'd6
    } state_t;

    state_t      state;
    logic [31:0] blocks_r;
    logic [31:0] ac_target;
    logic [31:0] phase_cnt;
    logic        dc_rst_n_r, dc_en_r;
    logic        ac_rst_n_r, ac_en_r, ac_start_r, ac_flush_r;

    logic        range_ok;
    logic        dc_count_en;
    logic        ac_count_en;
    logic [31:0] ac_sum;
    logic        overshoot;
    logic        timeout;
    logic        kill;

    assign vld.dc_vld_reset_n     = dc_rst_n_r;
    assign vld.dc_vld_enable      = dc_en_r;
    assign vld.ac_vld_reset_n     = ac_rst_n_r;
    assign vld.ac_vld_enable      = ac_en_r;
    assign vld.ac_vld_input_start = ac_start_r;
    assign vld.ac_vld_flush       = ac_flush_r;
    assign state_dbg              = state;

    // Decode which strobes count this cycle, and detect the abnormal exits.
    always_comb begin
        range_ok    = (block_num != 32'd0) && (block_num <= 32'(MAX_BLOCKS));
        dc_count_en = (state == DC_RUN) && vld.dc_vld_valid;
        ac_count_en = (state == AC_RUN) && vld.ac_vld_valid && (vld.ac_vld_pos_inc != 7'd0);
        ac_sum      = ac_vld_counter + {25'd0, vld.ac_vld_pos_inc};
        overshoot   = ac_count_en && (ac_sum > ac_target);
        kill        = abort || overshoot || timeout;
    end

`ifdef SEQ_TIMEOUT_EN
    logic [31:0] stall_cnt;
    logic        in_run;

    assign in_run  = (state == DC_RUN) || (state == AC_RUN);
    assign timeout = in_run && !dc_count_en && !ac_count_en &&
                     (stall_cnt == 32'(TIMEOUT_CYCLES - 1));

    // Stall watchdog. It is zero outside the run states, so it starts from
    // zero on every run-state entry. It also clears on each counted strobe.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= 32'd0;
        end else if (in_run && !dc_count_en && !ac_count_en && !timeout) begin
            stall_cnt <= stall_cnt + 32'd1;
        end else begin
            stall_cnt <= 32'd0;
        end
    end
`else
    logic [31:0] unused_timeout_cycles;
    assign unused_timeout_cycles = 32'(TIMEOUT_CYCLES);
    assign timeout               = 1'b0;
`endif

    // Main sequencer FSM. All outputs are registered here.
    // Abort, overshoot and timeout all return every output to its reset value.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            busy           <= 1'b0;
            blocks_r       <= 32'd0;
            ac_target      <= 32'd0;
            phase_cnt      <= 32'd0;
            dc_vld_counter <= 32'd0;
            ac_vld_counter <= 32'd0;
            dc_rst_n_r     <= 1'b0;
            dc_en_r        <= 1'b0;
            ac_rst_n_r     <= 1'b0;
            ac_en_r        <= 1'b0;
            ac_start_r     <= 1'b0;
            ac_flush_r     <= 1'b0;
            idct_enable    <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
        end else if (kill) begin
            state          <= IDLE;
            busy           <= 1'b0;
            phase_cnt      <= 32'd0;
            dc_vld_counter <= 32'd0;
            ac_vld_counter <= 32'd0;
            dc_rst_n_r     <= 1'b0;
            dc_en_r        <= 1'b0;
            ac_rst_n_r     <= 1'b0;
            ac_en_r        <= 1'b0;
            ac_start_r     <= 1'b0;
            ac_flush_r     <= 1'b0;
            idct_enable    <= 1'b0;
            done           <= 1'b0;
            error          <= !abort;
        end else begin
            done       <= 1'b0;
            error      <= 1'b0;
            ac_start_r <= 1'b0;
            ac_flush_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (range_ok) begin
                            blocks_r       <= block_num;
                            ac_target      <= (block_num << 6) - block_num;
                            dc_vld_counter <= 32'd0;
                            ac_vld_counter <= 32'd0;
                            phase_cnt      <= 32'd0;
                            busy           <= 1'b1;
                            state          <= DC_INIT;
                        end else begin
                            error <= 1'b1;
                        end
                    end
                end
                DC_INIT: begin
                    if (phase_cnt == 32'(RESET_CYCLES - 1)) begin
                        phase_cnt  <= 32'd0;
                        dc_rst_n_r <= 1'b1;
                        dc_en_r    <= 1'b1;
                        state      <= DC_RUN;
                    end else begin
                        phase_cnt <= phase_cnt + 32'd1;
                    end
                end
                DC_RUN: begin
                    if (dc_count_en) begin
                        dc_vld_counter <= dc_vld_counter + 32'd1;
                        if (dc_vld_counter + 32'd1 == blocks_r) begin
                            dc_en_r    <= 1'b0;
                            dc_rst_n_r <= 1'b0;
                            state      <= AC_INIT;
                        end
                    end
                end
                AC_INIT: begin
                    if (phase_cnt == 32'(RESET_CYCLES - 1)) begin
                        phase_cnt  <= 32'd0;
                        ac_rst_n_r <= 1'b1;
                        ac_en_r    <= 1'b1;
                        ac_start_r <= 1'b1;
                        state      <= AC_RUN;
                    end else begin
                        phase_cnt <= phase_cnt + 32'd1;
                    end
                end
                AC_RUN: begin
                    if (ac_count_en) begin
                        ac_vld_counter <= ac_sum;
                        if (ac_sum == ac_target) begin
                            ac_en_r     <= 1'b0;
                            ac_flush_r  <= 1'b1;
                            idct_enable <= 1'b1;
                            phase_cnt   <= 32'd0;
                            state       <= IDCT;
                        end
                    end
                end
                IDCT: begin
                    if (phase_cnt == 32'(IDCT_LATENCY - 1)) begin
                        phase_cnt   <= 32'd0;
                        idct_enable <= 1'b0;
                        done        <= 1'b1;
                        dc_rst_n_r  <= 1'b0;
                        ac_rst_n_r  <= 1'b0;
                        state       <= DONE;
                    end else begin
                        phase_cnt <= phase_cnt + 32'd1;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_component_decode_sequencer.sv
// Self-checking bench for component_decode_sequencer.
// The model computes each component's outcome from coefficient arithmetic:
//   - DC phase: count == block_num.
//   - AC phase: positions must total block_num * 63.
//     An exact hit means done; going past the total means error.
module tb_component_decode_sequencer;

    localparam int TO_CYCLES = 16;
    localparam int IDCT_LAT  = 10;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] block_num = 32'd0;
    logic        busy, idct_enable, done, error;
    logic [31:0] dc_vld_counter, ac_vld_counter;
    logic [2:0]  state_dbg;

    component_decode_sequencer_if vif();

    component_decode_sequencer #(
        .RESET_CYCLES(1), .IDCT_LATENCY(IDCT_LAT), .MAX_BLOCKS(32), .TIMEOUT_CYCLES(TO_CYCLES)
    ) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .abort(abort), .block_num(block_num),
        .vld(vif.master), .busy(busy), .dc_vld_counter(dc_vld_counter),
        .ac_vld_counter(ac_vld_counter), .idct_enable(idct_enable), .done(done),
        .error(error), .state_dbg(state_dbg)
    );

    // Clock and reset generation: 10 ns period.
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Pulse monitor: counts output activity, sampled on the falling edge.
    int n_done = 0, n_error = 0, n_flush = 0, n_istart = 0, n_idct = 0;
    always @(negedge clock) begin
        if (done) n_done++;
        if (error) n_error++;
        if (vif.ac_vld_flush) n_flush++;
        if (vif.ac_vld_input_start) n_istart++;
        if (idct_enable) n_idct++;
    end

    int          inc_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] obs_q[$];
    logic        flush_after_last;
    logic        err_after_last;
    int          exp_done;

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_start(input logic [31:0] bn);
        block_num = bn;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_sig(input int which, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if ((which == 0 && vif.dc_vld_enable) || (which == 1 && vif.ac_vld_enable) ||
                (which == 2 && done)) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic drive_dc(input int n);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            vif.dc_vld_valid = 1'b1;
            tick();
            vif.dc_vld_valid = 1'b0;
        end
    endtask

    task automatic drive_ac(input bit gaps);
        obs_q.delete();
        foreach (inc_q[i]) begin
            if (gaps) repeat ($urandom_range(0, 2)) tick();
            vif.ac_vld_valid   = 1'b1;
            vif.ac_vld_pos_inc = 7'(inc_q[i]);
            tick();
            vif.ac_vld_valid   = 1'b0;
            vif.ac_vld_pos_inc = 7'd0;
            obs_q.push_back(ac_vld_counter);
        end
        flush_after_last = vif.ac_vld_flush;
        err_after_last   = error;
    endtask

    // Reference model: the expected AC counter after each pair, and the outcome.
    task automatic build_exp(input int bn);
        int target;
        int sum;
        target = bn * 63;
        sum = 0;
        exp_done = 0;
        exp_q.delete();
        foreach (inc_q[i]) begin
            sum += inc_q[i];
            if (sum > target) exp_q.push_back(32'd0);
            else exp_q.push_back(32'(sum));
        end
        if (sum == target) exp_done = 1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        tick(); tick();
        checks++;
        if ({busy, vif.dc_vld_reset_n, vif.dc_vld_enable, vif.ac_vld_reset_n, vif.ac_vld_enable,
             vif.ac_vld_input_start, vif.ac_vld_flush, idct_enable, done, error} !== 10'd0) begin
            errors++; $display("FAIL reset_scalars got %b want 0", {busy, vif.dc_vld_reset_n,
                vif.dc_vld_enable, vif.ac_vld_reset_n, vif.ac_vld_enable, vif.ac_vld_input_start,
                vif.ac_vld_flush, idct_enable, done, error});
        end
        checks++;
        if (dc_vld_counter !== 32'd0 || ac_vld_counter !== 32'd0) begin
            errors++; $display("FAIL reset_counters got %0d/%0d want 0/0", dc_vld_counter, ac_vld_counter);
        end
        checks++;
        if (state_dbg !== 3'd0) begin
            errors++; $display("FAIL reset_state got %0d want 0", state_dbg);
        end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_nominal();
        bit ok;
        int b_istart, b_flush, b_idct, b_done, b_err;
        b_istart = n_istart; b_flush = n_flush; b_idct = n_idct; b_done = n_done; b_err = n_error;
        inc_q = '{63, 63, 63, 63};
        build_exp(4);
        drive_start(32'd4);
        wait_sig(0, ok);
        checks++; if (!ok) begin errors++; $display("FAIL nominal_dc_wait got timeout want dc_enable"); end
        drive_dc(4);
        checks++;
        if (dc_vld_counter !== 32'd4) begin errors++; $display("FAIL nominal_dc_count got %0d want 4", dc_vld_counter); end
        wait_sig(1, ok);
        checks++; if (!ok) begin errors++; $display("FAIL nominal_ac_wait got timeout want ac_enable"); end
        drive_ac(1'b1);
        foreach (exp_q[i]) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL nominal_ac_count[%0d] got %0d want %0d", i, obs_q[i], exp_q[i]); end
        end
        wait_sig(2, ok);
        checks++; if (!ok) begin errors++; $display("FAIL nominal_done_wait got timeout want done"); end
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL nominal_busy_after got %b want 0", busy); end
        checks++; if (n_istart - b_istart != 1) begin errors++; $display("FAIL nominal_istart got %0d want 1", n_istart - b_istart); end
        checks++; if (n_flush - b_flush != 1) begin errors++; $display("FAIL nominal_flush got %0d want 1", n_flush - b_flush); end
        checks++; if (n_idct - b_idct != IDCT_LAT) begin errors++; $display("FAIL nominal_idct got %0d want %0d", n_idct - b_idct, IDCT_LAT); end
        checks++; if (n_done - b_done != 1) begin errors++; $display("FAIL nominal_done got %0d want 1", n_done - b_done); end
        checks++; if (n_error != b_err) begin errors++; $display("FAIL nominal_error got %0d want 0", n_error - b_err); end
    endtask

    task automatic test_mixed();
        bit ok;
        int b_err, b_done;
        b_err = n_error; b_done = n_done;
        inc_q = '{1, 10, 52};
        build_exp(1);
        drive_start(32'd1);
        wait_sig(0, ok);
        drive_dc(1);
        wait_sig(1, ok);
        checks++; if (!ok) begin errors++; $display("FAIL mixed_ac_wait got timeout want ac_enable"); end
        drive_ac(1'b0);
        foreach (exp_q[i]) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL mixed_ac_count[%0d] got %0d want %0d", i, obs_q[i], exp_q[i]); end
        end
        checks++; if (flush_after_last !== 1'b1) begin errors++; $display("FAIL mixed_flush got %b want 1", flush_after_last); end
        wait_sig(2, ok);
        tick();
        checks++; if (n_done - b_done != 1) begin errors++; $display("FAIL mixed_done got %0d want 1", n_done - b_done); end
        checks++; if (n_error != b_err) begin errors++; $display("FAIL mixed_error got %0d want 0", n_error - b_err); end
    endtask

    task automatic test_overshoot();
        bit ok;
        int b_done;
        b_done = n_done;
        inc_q = '{60, 4};
        build_exp(1);
        drive_start(32'd1);
        wait_sig(0, ok);
        drive_dc(1);
        wait_sig(1, ok);
        drive_ac(1'b1);
        foreach (exp_q[i]) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL over_ac_count[%0d] got %0d want %0d", i, obs_q[i], exp_q[i]); end
        end
        checks++; if (err_after_last !== 1'b1) begin errors++; $display("FAIL over_error got %b want 1", err_after_last); end
        checks++; if (busy !== 1'b0 || vif.ac_vld_enable !== 1'b0) begin
            errors++; $display("FAIL over_idle got busy=%b en=%b want 0/0", busy, vif.ac_vld_enable); end
        repeat (IDCT_LAT + 3) tick();
        checks++; if (n_done != b_done) begin errors++; $display("FAIL over_done got %0d want 0", n_done - b_done); end
    endtask

    task automatic test_range();
        drive_start(32'd0);
        checks++; if (error !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL range_zero got err=%b busy=%b want 1/0", error, busy); end
        tick();
        drive_start(32'd33);
        checks++; if (error !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL range_33 got err=%b busy=%b want 1/0", error, busy); end
        tick();
        drive_start(32'd32);
        checks++; if (error !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL range_32 got err=%b busy=%b want 0/1", error, busy); end
        abort = 1'b1; tick(); abort = 1'b0;
        checks++; if (busy !== 1'b0 || error !== 1'b0) begin
            errors++; $display("FAIL range_abort got busy=%b err=%b want 0/0", busy, error); end
    endtask

    task automatic test_abort();
        bit ok;
        int b_flush, b_done, b_err;
        drive_start(32'd1);
        wait_sig(0, ok);
        drive_dc(1);
        wait_sig(1, ok);
        inc_q = '{60};
        drive_ac(1'b0);
        b_flush = n_flush; b_done = n_done; b_err = n_error;
        vif.ac_vld_valid = 1'b1; vif.ac_vld_pos_inc = 7'd3; abort = 1'b1;
        tick();
        vif.ac_vld_valid = 1'b0; vif.ac_vld_pos_inc = 7'd0; abort = 1'b0;
        checks++; if (busy !== 1'b0 || ac_vld_counter !== 32'd0 || vif.ac_vld_flush !== 1'b0) begin
            errors++; $display("FAIL abort_idle got busy=%b cnt=%0d flush=%b want 0/0/0", busy, ac_vld_counter, vif.ac_vld_flush); end
        repeat (IDCT_LAT + 3) tick();
        checks++; if (n_flush != b_flush || n_done != b_done || n_error != b_err) begin
            errors++; $display("FAIL abort_pulses got flush=%0d done=%0d err=%0d want 0/0/0",
                n_flush - b_flush, n_done - b_done, n_error - b_err); end
    endtask

    task automatic test_async_reset();
        bit ok;
        drive_start(32'd2);
        wait_sig(0, ok);
        vif.dc_vld_valid = 1'b1; tick(); vif.dc_vld_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || dc_vld_counter !== 32'd0 || vif.dc_vld_enable !== 1'b0 ||
                      vif.dc_vld_reset_n !== 1'b0 || state_dbg !== 3'd0) begin
            errors++; $display("FAIL async_reset got busy=%b cnt=%0d en=%b rn=%b st=%0d want all 0",
                busy, dc_vld_counter, vif.dc_vld_enable, vif.dc_vld_reset_n, state_dbg); end
        #1 reset_n = 1'b1;
        tick();
    endtask

    task automatic test_timeout();
        bit ok;
        int b_err;
        b_err = n_error;
        drive_start(32'd2);
        wait_sig(0, ok);
        repeat (TO_CYCLES + 4) tick();
`ifdef SEQ_TIMEOUT_EN
        checks++; if (n_error - b_err != 1 || busy !== 1'b0) begin
            errors++; $display("FAIL timeout got err=%0d busy=%b want 1/0", n_error - b_err, busy); end
`else
        checks++; if (n_error != b_err || busy !== 1'b1) begin
            errors++; $display("FAIL no_timeout got err=%0d busy=%b want 0/1", n_error - b_err, busy); end
`endif
        abort = 1'b1; tick(); abort = 1'b0;
    endtask

    task automatic test_random();
        bit ok;
        int bn, rem, inc;
        bit over;
        int b_done, b_err, b_flush, b_idct, b_istart;
        for (int it = 0; it < 12; it++) begin
            bn = $urandom_range(1, 32);
            rem = bn * 63;
            over = ($urandom_range(0, 2) == 0);
            inc_q.delete();
            while (rem > 0) begin
                if ($urandom_range(0, 7) == 0) inc_q.push_back(0);
                if (over && rem < 64) begin
                    inc = $urandom_range(rem + 1, 64);
                    rem = 0;
                end else begin
                    inc = $urandom_range(1, (rem < 64) ? rem : 64);
                    rem -= inc;
                end
                inc_q.push_back(inc);
            end
            build_exp(bn);
            b_done = n_done; b_err = n_error; b_flush = n_flush; b_idct = n_idct; b_istart = n_istart;
            drive_start(32'(bn));
            wait_sig(0, ok);
            checks++; if (!ok) begin errors++; $display("FAIL rand_dc_wait[%0d] got timeout want dc_enable", it); end
            drive_dc(bn);
            checks++;
            if (dc_vld_counter !== 32'(bn)) begin errors++; $display("FAIL rand_dc_count[%0d] got %0d want %0d", it, dc_vld_counter, bn); end
            wait_sig(1, ok);
            checks++; if (!ok) begin errors++; $display("FAIL rand_ac_wait[%0d] got timeout want ac_enable", it); end
            drive_ac(1'b1);
            foreach (exp_q[i]) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_ac_count[%0d][%0d] got %0d want %0d", it, i, obs_q[i], exp_q[i]); end
            end
            if (exp_done == 1) begin
                wait_sig(2, ok);
                checks++; if (!ok) begin errors++; $display("FAIL rand_done_wait[%0d] got timeout want done", it); end
            end
            tick();
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rand_busy[%0d] got %b want 0", it, busy); end
            checks++; if (n_done - b_done != exp_done || n_error - b_err != 1 - exp_done) begin
                errors++; $display("FAIL rand_outcome[%0d] got done=%0d err=%0d want %0d/%0d", it,
                    n_done - b_done, n_error - b_err, exp_done, 1 - exp_done); end
            checks++; if (n_flush - b_flush != exp_done || n_idct - b_idct != exp_done * IDCT_LAT) begin
                errors++; $display("FAIL rand_flush_idct[%0d] got %0d/%0d want %0d/%0d", it,
                    n_flush - b_flush, n_idct - b_idct, exp_done, exp_done * IDCT_LAT); end
            checks++; if (n_istart - b_istart != 1) begin errors++; $display("FAIL rand_istart[%0d] got %0d want 1", it, n_istart - b_istart); end
        end
    endtask

    // Test sequence and final report.
    initial begin
        vif.dc_vld_valid   = 1'b0;
        vif.ac_vld_valid   = 1'b0;
        vif.ac_vld_pos_inc = 7'd0;
        test_reset();
        test_nominal();
        test_mixed();
        test_overshoot();
        test_range();
        test_abort();
        test_async_reset();
        test_timeout();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/component_decode_sequencer.md
Name: component_decode_sequencer

Overview:
- Control sequencer for the ProRes decode path, the decoder-side counterpart of the encoder's component sequencer.
- Decoded symbol lengths vary, so stages are handshake-driven rather than fixed-time:
  - DC VLD runs first, then AC run/level VLD (with input start/flush), then a fixed-latency dequant/IDCT window.
  - The sequencer counts decoded coefficients and signals done or error per slice component.

Parameters:
- RESET_CYCLES, 1: cycles each VLD reset_n is held low before its run phase.
- IDCT_LATENCY, 10: cycles idct_enable stays high after AC completes.
- MAX_BLOCKS, 32: largest legal block_num.
- TIMEOUT_CYCLES, 4096: stall limit; used only with the optional feature.

Ports:
- clock  in  1  single clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  start pulse; sampled in IDLE only.
- abort  in  1  synchronous abort; valid in any state.
- block_num  in  32  blocks in this component; latched on accepted start.
- dc_vld_valid  in  1  DC decoder produced one DC coefficient this cycle.
- ac_vld_valid  in  1  AC decoder produced one run/level pair this cycle.
- ac_vld_pos_inc  in  7  positions consumed by that pair (run+1), range 1..64; value 0 is ignored.
- busy  out  1  high in every state except IDLE.
- dc_vld_reset_n  out  1  active-low reset to the DC decoder.
- dc_vld_enable  out  1  DC decoder run enable.
- dc_vld_counter  out  32  DC coefficients received.
- ac_vld_reset_n  out  1  active-low reset to the AC decoder.
- ac_vld_input_start  out  1  one-cycle pulse on the first AC_RUN cycle.
- ac_vld_enable  out  1  AC decoder run enable.
- ac_vld_flush  out  1  one-cycle pulse when AC completes.
- ac_vld_counter  out  32  AC positions accumulated.
- idct_enable  out  1  IDCT window.
- done  out  1  one-cycle completion pulse.
- error  out  1  one-cycle error pulse.

Behaviour:
- Reset values:
  - State is IDLE.
  - All outputs are 0, so both VLD reset_n outputs are low (decoders held in reset).
  - All counters are 0.
- IDLE:
  - start=1 with 1 ≤ block_num ≤ MAX_BLOCKS: latch block_num, compute ac_target = (block_num<<6) − block_num, clear counters, go to DC_INIT.
  - start=1 with block_num out of range: error pulse next cycle, remain in IDLE.
- DC_INIT:
  - dc_vld_reset_n stays 0 for RESET_CYCLES cycles, then go to DC_RUN.
- DC_RUN:
  - dc_vld_reset_n=1 and dc_vld_enable=1.
  - Each dc_vld_valid increments dc_vld_counter.
  - On the valid that makes the count equal block_num: next cycle dc_vld_enable=0, dc_vld_reset_n=0, go to AC_INIT.
- AC_INIT:
  - ac_vld_reset_n stays 0 for RESET_CYCLES cycles, then go to AC_RUN.
- AC_RUN:
  - ac_vld_reset_n=1 and ac_vld_enable=1; ac_vld_input_start is high for the first cycle only.
  - On each ac_vld_valid, add ac_vld_pos_inc to ac_vld_counter (32-bit, no wrap; block_num ≤ MAX_BLOCKS keeps it bounded).
  - Sum equals ac_target: next cycle ac_vld_enable=0, ac_vld_flush=1 for exactly one cycle, go to IDCT.
  - Sum exceeds ac_target: error pulse, every output returns to its reset value, go to IDLE; done is not asserted.
  - If ac_vld_valid coincides with the input_start cycle, it is counted.
- IDCT:
  - idct_enable=1 for exactly IDCT_LATENCY cycles, then go to DONE.
- DONE:
  - done=1 for one cycle; both VLD reset_n outputs return to 0; go to IDLE.
  - busy drops in the same cycle the state becomes IDLE.
- Ignored inputs:
  - dc_vld_valid outside DC_RUN is ignored.
  - ac_vld_valid outside AC_RUN is ignored.
- abort=1 in any state: next cycle is IDLE with all outputs at reset values; no done or error pulse. abort takes priority over start and over completion in the same cycle.
- Asynchronous reset mid-operation: immediately returns to reset values.
- start while busy is ignored.

Optional Feature:
- Macro: SEQ_TIMEOUT_EN.
- Defined:
  - A stall counter clears on every counted valid and on state entry.
  - In DC_RUN or AC_RUN, if it reaches TIMEOUT_CYCLES: error pulse, all outputs to reset values, go to IDLE.
- Undefined:
  - No stall counter; the run states wait indefinitely.
  - error comes only from a range error or AC overshoot.

Test Plan:
- Nominal, block_num=4 → dc_vld_counter reaches 4.
  - AC stimulus: pos_inc=63 ×4 → ac_vld_counter=252.
  - Exactly one flush pulse and one input_start pulse.
  - idct_enable high for 10 cycles, then one done pulse; busy low afterwards.
- Mixed AC increments, block_num=1 → pos_inc 1,10,52 sums to 63 → flush on the cycle after the third valid; no error.
- AC overshoot, block_num=1 → pos_inc 60 then 4 (sum 64) → error pulse, return to IDLE, no done, ac_vld_enable=0.
- Range check → start with block_num=0 and with 33 → error pulse each time, busy stays 0; start with 32 is accepted.
- Abort and reset:
  - abort asserted in AC_RUN together with a completing valid → IDLE, no flush, no done.
  - reset_n asserted low in DC_RUN → all outputs 0 asynchronously.
- With SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=16:
  - No dc_vld_valid for 16 cycles → error pulse, IDLE.
  - Same stimulus built without the macro → remains busy.
